// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory initiator: size codes, sign-mask encodings,
// FSM state type and the default LED MMIO address.
package data_mem_pkg;

   localparam logic [1:0]  SIZE_BYTE    = 2'd0;
   localparam logic [1:0]  SIZE_HALF    = 2'd1;
   localparam logic [1:0]  SIZE_WORD    = 2'd2;
   localparam logic [1:0]  SIZE_ILLEGAL = 2'd3;

   localparam logic [2:0]  SIGN_MASK_BYTE = 3'b001;
   localparam logic [2:0]  SIGN_MASK_HALF = 3'b011;
   localparam logic [2:0]  SIGN_MASK_WORD = 3'b111;

   localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_LCAP  = 3'd2,
      ST_SWAIT = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   // data_mem sign_mask: {signed, size code}
   function automatic logic [3:0] sign_mask_f(input logic sgn, input logic [1:0] size);
      logic [3:0] mask;
      case (size)
         SIZE_BYTE: mask = {sgn, SIGN_MASK_BYTE};
         SIZE_HALF: mask = {sgn, SIGN_MASK_HALF};
         SIZE_WORD: mask = {sgn, SIGN_MASK_WORD};
         default:   mask = 4'b0000;
      endcase
      return mask;
   endfunction

   function automatic logic aligned_f(input logic [1:0] addr_lsb, input logic [1:0] size);
      logic ok;
      case (size)
         SIZE_BYTE: ok = 1'b1;
         SIZE_HALF: ok = ~addr_lsb[0];
         SIZE_WORD: ok = (addr_lsb == 2'b00);
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_mem_master_stats.sv
// Saturating 16-bit activity counters for data_mem_master (used only when
// DATA_MEM_MASTER_STATS_EN is defined).
module data_mem_master_stats (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_done,
   input  logic        store_done,
   input  logic        err_done,
   input  logic        stall_cycle,
   output logic [15:0] stat_loads,
   output logic [15:0] stat_stores,
   output logic [15:0] stat_errs,
   output logic [15:0] stat_stalls
);

   function automatic logic [15:0] sat_inc_f(input logic [15:0] v, input logic en);
      logic [15:0] r;
      if (en && (v != 16'hFFFF)) begin
         r = v + 16'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_loads  <= 16'd0;
         stat_stores <= 16'd0;
         stat_errs   <= 16'd0;
         stat_stalls <= 16'd0;
      end else begin
         stat_loads  <= sat_inc_f(stat_loads,  load_done);
         stat_stores <= sat_inc_f(stat_stores, store_done);
         stat_errs   <= sat_inc_f(stat_errs,   err_done);
         stat_stalls <= sat_inc_f(stat_stalls, stall_cycle);
      end
   end

endmodule

// File: rtl/data_mem_master.sv
// Load/store initiator for the data-memory port (valid/ready in, data_mem strobes out),
// including LED MMIO stores. Define DATA_MEM_MASTER_STATS_EN to add activity counters.
module data_mem_master
   import data_mem_pkg::*;
#(
   parameter int unsigned MEM_BYTES     = 4096,
   parameter logic [31:0] LED_ADDR      = LED_ADDR_DEFAULT,
   parameter int unsigned STALL_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [3:0]  req_tag,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [3:0]  rsp_tag,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_memwrite,
   output logic        mem_memread,
   output logic [3:0]  mem_sign_mask,
   input  logic [31:0] mem_read_data,
   input  logic        mem_clk_stall
`ifdef DATA_MEM_MASTER_STATS_EN
   ,
   output logic [15:0] stat_loads,
   output logic [15:0] stat_stores,
   output logic [15:0] stat_errs,
   output logic [15:0] stat_stalls
`endif
);

   localparam int unsigned TIMER_W = $clog2(STALL_TIMEOUT + 1);

   state_e             state_r, state_s;
   logic [TIMER_W-1:0] timer_r, timer_s;
   logic               we_r;
   logic [3:0]         tag_r;
   logic               accept_s, req_ok_s;
   logic               rsp_load_s, rsp_err_s;
   logic               issue_s, ready_s, rsp_valid_s, memread_s, memwrite_s;

   assign accept_s = req_valid && req_ready;

   // Request legality: size, alignment, data window, LED address is store-only.
   always_comb begin
      if ((req_size != SIZE_ILLEGAL) && aligned_f(req_addr[1:0], req_size)) begin
         req_ok_s = (req_addr < 32'(MEM_BYTES)) || (req_we && (req_addr == LED_ADDR));
      end else begin
         req_ok_s = 1'b0;
      end
   end

   // Next state, stall timer and response-capture decisions.
   always_comb begin
      state_s    = state_r;
      timer_s    = timer_r;
      rsp_load_s = 1'b0;
      rsp_err_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            timer_s = {TIMER_W{1'b0}};
            if (accept_s && req_ok_s) begin
               state_s = ST_ISSUE;
            end else if (accept_s) begin
               state_s    = ST_RESP;
               rsp_load_s = 1'b1;
               rsp_err_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (we_r) begin
               state_s = ST_SWAIT;
            end else begin
               state_s = ST_LCAP;
            end
         end
         ST_LCAP: begin
            state_s    = ST_RESP;
            rsp_load_s = 1'b1;
         end
         ST_SWAIT: begin
            if (!mem_clk_stall) begin
               state_s    = ST_RESP;
               rsp_load_s = 1'b1;
            end else if (timer_r == TIMER_W'(STALL_TIMEOUT - 1)) begin
               state_s    = ST_RESP;
               rsp_load_s = 1'b1;
               rsp_err_s  = 1'b1;
            end else begin
               timer_s = timer_r + TIMER_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; strobes are single-cycle by construction.
   always_comb begin
      issue_s     = (state_r == ST_IDLE) && (state_s == ST_ISSUE);
      ready_s     = (state_s == ST_IDLE);
      rsp_valid_s = (state_s == ST_RESP);
      if (issue_s) begin
         memread_s  = ~req_we;
         memwrite_s = req_we;
      end else begin
         memread_s  = 1'b0;
         memwrite_s = 1'b0;
      end
   end

   // State, request latches and registered outputs; reset abandons any transaction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         timer_r        <= {TIMER_W{1'b0}};
         we_r           <= 1'b0;
         tag_r          <= 4'd0;
         req_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_data       <= 32'd0;
         rsp_tag        <= 4'd0;
         rsp_err        <= 1'b0;
         mem_addr       <= 32'd0;
         mem_write_data <= 32'd0;
         mem_memwrite   <= 1'b0;
         mem_memread    <= 1'b0;
         mem_sign_mask  <= 4'd0;
      end else begin
         state_r      <= state_s;
         timer_r      <= timer_s;
         req_ready    <= ready_s;
         rsp_valid    <= rsp_valid_s;
         mem_memread  <= memread_s;
         mem_memwrite <= memwrite_s;
         if (accept_s) begin
            we_r  <= req_we;
            tag_r <= req_tag;
         end
         if (issue_s) begin
            mem_addr       <= req_addr;
            mem_write_data <= req_wdata;
            mem_sign_mask  <= sign_mask_f(req_signed, req_size);
         end
         if (rsp_load_s) begin
            rsp_err  <= rsp_err_s;
            rsp_tag  <= (state_r == ST_IDLE) ? req_tag : tag_r;
            rsp_data <= (state_r == ST_LCAP) ? mem_read_data : 32'd0;
         end
      end
   end

`ifdef DATA_MEM_MASTER_STATS_EN
   logic rsp_fire_s;
   assign rsp_fire_s = rsp_valid && rsp_ready;

   data_mem_master_stats u_stats (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_done   (rsp_fire_s && !we_r && !rsp_err),
      .store_done  (rsp_fire_s && we_r && !rsp_err),
      .err_done    (rsp_fire_s && rsp_err),
      .stall_cycle ((state_r == ST_SWAIT) && mem_clk_stall),
      .stat_loads  (stat_loads),
      .stat_stores (stat_stores),
      .stat_errs   (stat_errs),
      .stat_stalls (stat_stalls)
   );
`endif

endmodule

// File: tb/tb_data_mem_master.sv
// Self-checking bench for data_mem_master: directed cases plus randomized requests
// against a byte-array reference model, with a small data_mem model providing stalls.
module tb_data_mem_master;

   localparam logic [31:0] LED = 32'h0000_2000;
   localparam int          TO  = 15;

   logic        clk = 1'b0;
   logic        rst_n, req_valid, req_ready, req_we, req_signed;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic [3:0]  req_tag;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_tag;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;
   logic        mem_memwrite, mem_memread, mem_clk_stall;
   logic [3:0]  mem_sign_mask;

   logic        tb_init, stall_force;
   int          stall_cycles, stall_cnt;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  ref_mem [0:4095];
   logic [7:0]  dm_mem  [0:4095];
   logic [31:0] dm_led;

   always #5 clk = ~clk;

   data_mem_master dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
      .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h, expected %08h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 73) ^ 90);
   endfunction

   // ---------------- data_mem environment model ----------------
   function automatic int mask_bytes(input logic [3:0] m);
      case (m[2:0])
         3'b001:  return 1;
         3'b011:  return 2;
         3'b111:  return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] dm_read(input logic [31:0] a, input logic [3:0] m);
      logic [31:0] v;
      int nb;
      nb = mask_bytes(m);
      v  = 32'h0;
      for (int i = 0; i < 4; i++)
         if (i < nb) v[8*i +: 8] = dm_mem[a[11:0] + 12'(i)];
      if (m[3] && nb == 1) v[31:8] = {24{v[7]}};
      else if (m[3] && nb == 2) v[31:16] = {16{v[15]}};
      return v;
   endfunction

   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 4096; i++) dm_mem[i] <= init_byte(i);
         stall_cnt     <= 0;
         dm_led        <= 32'h0;
         mem_read_data <= 32'h0;
      end else begin
         if (stall_cnt > 0) stall_cnt <= stall_cnt - 1;
         if (mem_memwrite) begin
            if (mem_addr == LED) begin
               dm_led <= mem_write_data;
            end else begin
               if (mem_addr < 32'd4096)
                  for (int i = 0; i < 4; i++)
                     if (i < mask_bytes(mem_sign_mask))
                        dm_mem[mem_addr[11:0] + 12'(i)] <= mem_write_data[8*i +: 8];
               stall_cnt <= stall_cycles;
            end
         end
         if (mem_memread && mem_addr < 32'd4096)
            mem_read_data <= dm_read(mem_addr, mem_sign_mask);
      end
   end

   assign mem_clk_stall = stall_force | (stall_cnt > 0);

   // ---------------- reference model ----------------
   function automatic bit ref_err(input logic we, input logic [31:0] a, input logic [1:0] sz);
      int unsigned nb;
      if (sz == 2'd3) return 1'b1;
      nb = 1 << sz;
      if (a % nb != 0) return 1'b1;
      if (a == LED) return !we;
      return !(a < 32'd4096);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
      longint v;
      int     nb;
      nb = 1 << sz;
      v  = 0;
      for (int i = nb - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[int'(a) + i]);
      if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      return v[31:0];
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      int nb;
      nb = 1 << sz;
      for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = 8'(d >> (8 * i));
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sgn, input logic [3:0] tag,
                         input int stall_n, input int hold);
      bit          pre_err, e_err;
      logic [31:0] e_data;
      int          e_lat, eff_stall, lat, rd_cnt, wr_cnt, n;
      pre_err   = ref_err(we, addr, size);
      eff_stall = (addr == LED) ? 0 : stall_n;
      e_err     = pre_err;
      if (pre_err)                                 e_lat = 1;
      else if (!we)                                e_lat = 3;
      else if (stall_force || eff_stall >= TO) begin e_lat = 2 + TO; e_err = 1'b1; end
      else                                         e_lat = 3 + eff_stall;
      e_data = (e_err || we) ? 32'h0 : ref_load(addr, size, sgn);
      stall_cycles = stall_n;

      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_size = size; req_signed = sgn; req_tag = tag;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      check("accept_in_time", 32'(n < 50), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;

      lat = 0; rd_cnt = 0; wr_cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         rd_cnt += int'(mem_memread);
         wr_cnt += int'(mem_memwrite);
      end while (rsp_valid !== 1'b1 && lat < 60);
      check("rsp_latency", 32'(lat), 32'(e_lat));
      check("rsp_err",     32'(rsp_err), 32'(e_err));
      check("rsp_data",    rsp_data, e_data);
      check("rsp_tag",     32'(rsp_tag), 32'(tag));
      check("memread_cycles",  32'(rd_cnt), 32'((!pre_err && !we) ? 1 : 0));
      check("memwrite_cycles", 32'(wr_cnt), 32'((!pre_err && we) ? 1 : 0));

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_data",  rsp_data, e_data);
         check("hold_tag",   32'(rsp_tag), 32'(tag));
         check("hold_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("valid_drop", 32'(rsp_valid), 32'd0);
      check("ready_back", 32'(req_ready), 32'd1);

      if (we && !e_err && addr < 32'd4096) ref_store(addr, wdata, size);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        we, sg;
      logic [1:0]  sz;
      logic [31:0] a;
      bit          seen;

      rst_n = 1'b0; tb_init = 1'b1; stall_force = 1'b0; stall_cycles = 0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      req_size = 2'd0; req_signed = 1'b0; req_tag = 4'h0; rsp_ready = 1'b0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err",   32'(rsp_err), 32'd0);
      check("rst_rsp_data",  rsp_data, 32'd0);
      check("rst_strobes",   32'({mem_memread, mem_memwrite}), 32'd0);
      check("rst_mem_addr",  mem_addr, 32'd0);
      check("rst_mask",      32'(mem_sign_mask), 32'd0);
      tb_init = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(req_ready), 32'd1);

      // directed cases
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 4'h1, 1, 0);
      do_req(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 4'h2, 0, 0);
      do_req(1'b1, 32'h11, 32'hABCDEF80, 2'd0, 1'b0, 4'h3, 1, 0);
      do_req(1'b0, 32'h11, 32'h0,        2'd0, 1'b1, 4'h4, 0, 0);
      do_req(1'b0, 32'h11, 32'h0,        2'd0, 1'b0, 4'h5, 0, 0);
      do_req(1'b0, 32'h13, 32'h0,        2'd1, 1'b0, 4'hA, 0, 0);
      do_req(1'b1, LED,    32'h0000_0005, 2'd2, 1'b0, 4'h6, 2, 0);
      check("led_value", dm_led, 32'h0000_0005);
      do_req(1'b0, LED,    32'h0,        2'd2, 1'b0, 4'h7, 0, 0);
      do_req(1'b0, 32'h20, 32'h0,        2'd3, 1'b0, 4'h8, 0, 0);
      do_req(1'b0, 32'h1000, 32'h0,      2'd0, 1'b0, 4'h9, 0, 0);
      stall_force = 1'b1;
      do_req(1'b1, LED,    32'h0000_0003, 2'd2, 1'b0, 4'hB, 0, 0);
      stall_force = 1'b0;
      do_req(1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 4'hC, 0, 5);

      // reset while waiting on a stalled store
      stall_force = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = LED; req_wdata = 32'h9; req_size = 2'd2; req_tag = 4'hD;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      check("midrst_rsp",       32'({rsp_valid, rsp_err, rsp_tag}), 32'd0);
      check("midrst_rsp_data",  rsp_data, 32'd0);
      check("midrst_strobes",   32'({mem_memread, mem_memwrite}), 32'd0);
      check("midrst_mem_addr",  mem_addr, 32'd0);
      check("midrst_wdata",     mem_write_data, 32'd0);
      check("midrst_mask",      32'(mem_sign_mask), 32'd0);
      rst_n = 1'b1; stall_force = 1'b0;
      seen = 1'b0;
      repeat (6) begin @(negedge clk); if (rsp_valid === 1'b1) seen = 1'b1; end
      check("midrst_no_rsp", 32'(seen), 32'd0);
      check("midrst_ready",  32'(req_ready), 32'd1);

      // randomized traffic
      for (int k = 0; k < 200; k++) begin
         we = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         case ($urandom_range(0, 9))
            0:       a = LED;
            1:       a = 32'h1000 + 32'($urandom_range(0, 64));
            default: a = 32'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 4) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            else if (sz == 2'd2) a[1:0] = 2'b00;
         end
         do_req(we, a, $urandom, sz, sg, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
